dpwm_deadtime_gen: RTL and testbench
====================================

// Module: dpwm_deadtime_gen
// PURPOSE
//  Parametrised digital PWM with programmable period and independent rise/fall dead times for a synchronous buck power stage.
//  Generates complementary high-side and low-side gate commands from a free-running period counter.
//  Duty, period and dead times are double-buffered and take effect only at a period boundary.
//  Adds enable, duty clamping against dead time, and a sticky fault shutdown.
//  Sits between the digital compensator (duty source) and the gate-driver pins.
// PARAMETERS
//  CNT_W   6   counter/period/duty width; max period = 2^CNT_W counts
//  DT_W    4   dead-time field width (counts)
// PORTS
//  clk          in   1       system clock, all logic on rising edge
//  rst_n        in   1       asynchronous, active-low reset
//  en           in   1       1 = PWM running; 0 = outputs low, counter held at 0
//  period       in   CNT_W   period-1 (counter terminal value), shadowed
//  duty         in   CNT_W   high-side on-time in counts, shadowed
//  dt_rise      in   DT_W    dead time HS-off -> LS-on (counts), shadowed
//  dt_fall      in   DT_W    dead time LS-off -> next HS-on (counts), shadowed
//  fault        in   1       synchronous fault request, level
//  fault_clr    in   1       clears latched fault
//  pwm_hs       out  1       high-side gate command (registered)
//  pwm_ls       out  1       low-side gate command (registered)
//  cnt          out  CNT_W   period counter value
//  period_start out  1       1-cycle pulse, registered, when cnt wraps to 0
//  fault_lat    out  1       latched fault status
// BEHAVIOUR
//  Reset: cnt=0, per_q=all ones, duty_q=0, dtr_q=0, dtf_q=0, pwm_hs=0, pwm_ls=0, period_start=0, fault_lat=0.
//  Counter: en=1 -> cnt increments; cnt==per_q -> cnt<=0 next cycle. en=0 -> cnt<=0.
//  Shadow load: per_q/duty_q/dtr_q/dtf_q <= inputs when (en=0) or (cnt==per_q); otherwise held.
//   A new period value never truncates the running period.
//  period_start <= en & (cnt==per_q); asserts together with the cycle where cnt shows 0.
//  Arithmetic in CNT_W+2 bits, unsigned, no wrap:
//   P = per_q+1; lim = P - dtr_q - dtf_q, saturated at 0; d_eff = min(duty_q, lim).
//   hs_nxt = (cnt < d_eff);  ls_nxt = (cnt >= d_eff+dtr_q) & (cnt+dtf_q < P).
//  Outputs: pwm_hs <= run & hs_nxt; pwm_ls <= run & ls_nxt; run = en & ~fault_lat & ~fault.
//   Latency: outputs reflect the cnt value of the previous cycle (1 clk).
//  Invariant: pwm_hs & pwm_ls never both 1, for any inputs. Both are low >= dtr_q counts after HS-off and >= dtf_q counts before HS-on.
//  duty=0 -> HS never on; LS still runs dtr..P-dtf-1. duty>=lim -> clamped, dead times preserved.
//  dtr+dtf >= P -> both outputs permanently low.
//  Fault: fault=1 -> fault_lat<=1; outputs low on the same edge (run uses raw fault).
//   fault_clr=1 & fault=0 -> fault_lat<=0. Simultaneous fault & fault_clr -> fault wins.
//   After clear, outputs resume at the current cnt; the counter is not reset by fault.
//  en deassert mid-period: outputs low next edge, cnt=0.
//   Re-assert: first period starts at cnt=0 with freshly loaded shadows.
//  Async reset mid-period: immediate return to reset values; outputs low without clock.
// TESTING
//  CNT_W=6,per=63,duty=20,dtr=6,dtf=6 -> pwm_hs high for cnt 0..19, pwm_ls high for cnt 26..57, 64-clk period.
//  Change duty 20->40 at cnt=10 -> current period keeps 20; next period_start onwards HS on for cnt 0..39.
//  per=31,duty=63,dtr=3,dtf=2 -> d_eff=27; HS cnt 0..26, LS cnt 30..29 = none, both low; never overlap.
//  per=31,dtr=15,dtf=15 -> lim=2; HS cnt 0..1; LS off (17..16 empty); check no overlap in every cycle.
//  fault pulse at cnt=5 -> both outputs 0 next edge; fault_lat=1; fault_clr+fault same cycle keeps latch.
//  fault_clr alone -> outputs resume at current cnt.
//  en low at cnt=30 then high -> outputs low, cnt=0, period_start after per_q+1 clks; rst_n low mid-period -> outputs 0 immediately.
//  Random duty/dt/period sweep, 10k cycles -> assert !(pwm_hs&pwm_ls) and dead-time gaps >= dtr_q/dtf_q.

Source files
------------

// File: rtl/dpwm_deadtime_gen.sv
// Digital PWM for a synchronous buck stage: complementary high/low-side gate commands
// with independent rise/fall dead times, period-boundary shadow registers and a sticky fault latch.
module dpwm_deadtime_gen #(
    parameter int CNT_W = 6,
    parameter int DT_W  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [CNT_W-1:0] period,
    input  logic [CNT_W-1:0] duty,
    input  logic [DT_W-1:0]  dt_rise,
    input  logic [DT_W-1:0]  dt_fall,
    input  logic             fault,
    input  logic             fault_clr,
    output logic             pwm_hs,
    output logic             pwm_ls,
    output logic [CNT_W-1:0] cnt,
    output logic             period_start,
    output logic             fault_lat
);

    // Two extra bits so P = per_q+1 and d_eff+dtr_q can never wrap.
    localparam int W = CNT_W + 2;

    logic [CNT_W-1:0] per_q;
    logic [CNT_W-1:0] duty_q;
    logic [DT_W-1:0]  dtr_q;
    logic [DT_W-1:0]  dtf_q;

    logic         at_end;
    logic         shadow_ld;
    logic         run;
    logic [W-1:0] cnt_x;
    logic [W-1:0] per_p1;
    logic [W-1:0] dt_sum;
    logic [W-1:0] lim;
    logic [W-1:0] d_eff;
    logic [W-1:0] ls_start;
    logic [W-1:0] cnt_tail;
    logic         hs_nxt;
    logic         ls_nxt;

    always_comb begin
        at_end    = (cnt == per_q);
        shadow_ld = ~en | at_end;
        run       = en & ~fault_lat & ~fault;

        cnt_x    = W'(cnt);
        per_p1   = W'(per_q) + W'(1);
        dt_sum   = W'(dtr_q) + W'(dtf_q);
        lim      = (per_p1 > dt_sum) ? (per_p1 - dt_sum) : '0;
        d_eff    = (W'(duty_q) < lim) ? W'(duty_q) : lim;
        ls_start = d_eff + W'(dtr_q);
        cnt_tail = cnt_x + W'(dtf_q);

        // Windows are disjoint by construction: HS ends at d_eff, LS starts at d_eff+dtr_q.
        hs_nxt = (cnt_x < d_eff);
        ls_nxt = (cnt_x >= ls_start) & (cnt_tail < per_p1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            per_q  <= '1;
            duty_q <= '0;
            dtr_q  <= '0;
            dtf_q  <= '0;
        end else begin
            if (!en || at_end) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
            if (shadow_ld) begin
                per_q  <= period;
                duty_q <= duty;
                dtr_q  <= dt_rise;
                dtf_q  <= dt_fall;
            end
        end
    end

    // Raw fault gates the outputs on the same edge that sets the latch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_hs       <= 1'b0;
            pwm_ls       <= 1'b0;
            period_start <= 1'b0;
            fault_lat    <= 1'b0;
        end else begin
            pwm_hs       <= run & hs_nxt;
            pwm_ls       <= run & ls_nxt;
            period_start <= en & at_end;
            if (fault) begin
                fault_lat <= 1'b1;
            end else if (fault_clr) begin
                fault_lat <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_dpwm_deadtime_gen.sv
// Self-checking bench for dpwm_deadtime_gen: directed scenarios plus a random sweep,
// with a behavioural scoreboard predicting every output cycle by cycle.
module tb_dpwm_deadtime_gen;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [5:0] period;
    logic [5:0] duty;
    logic [3:0] dt_rise;
    logic [3:0] dt_fall;
    logic       fault;
    logic       fault_clr;
    logic       pwm_hs;
    logic       pwm_ls;
    logic [5:0] cnt;
    logic       period_start;
    logic       fault_lat;

    dpwm_deadtime_gen #(.CNT_W(6), .DT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .period(period), .duty(duty),
        .dt_rise(dt_rise), .dt_fall(dt_fall), .fault(fault), .fault_clr(fault_clr),
        .pwm_hs(pwm_hs), .pwm_ls(pwm_ls), .cnt(cnt), .period_start(period_start),
        .fault_lat(fault_lat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       hs;
        logic       ls;
        logic       ps;
        logic       flt;
        logic [5:0] cnt;
    } exp_t;

    exp_t sb[$];

    int total = 0;
    int bad   = 0;

    int m_cnt, m_per, m_duty, m_dtr, m_dtf, m_flt;
    int cur_dtr, cur_dtf;
    int last_high, low_run, ls_dtf;
    bit prev_hs, prev_ls;
    int nh, nl, pa, lh, fl;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_ge(input string tag, input int obs, input int lo);
        total++;
        assert (obs >= lo) else begin
            bad++;
            $error("FAIL %s observed=%0d required_min=%0d", tag, obs, lo);
        end
    endtask

    task automatic reset_model();
        m_cnt = 0; m_per = 63; m_duty = 0; m_dtr = 0; m_dtf = 0; m_flt = 0;
        last_high = 0; low_run = 0; ls_dtf = 0; prev_hs = 0; prev_ls = 0;
    endtask

    // Predict the next registered outputs from the current inputs, clock once, compare.
    task automatic tick();
        exp_t e;
        int p, lim, de, nxt;
        bit run;
        p   = m_per + 1;
        lim = p - m_dtr - m_dtf;
        if (lim < 0) lim = 0;
        de  = (m_duty < lim) ? m_duty : lim;
        run = en && !m_flt && !fault;
        e.hs  = run && (m_cnt < de);
        e.ls  = run && (m_cnt >= de + m_dtr) && (m_cnt < p - m_dtf);
        e.ps  = en && (m_cnt == m_per);
        cur_dtr = m_dtr;
        cur_dtf = m_dtf;
        nxt = (!en || m_cnt == m_per) ? 0 : m_cnt + 1;
        if (!en || m_cnt == m_per) begin
            m_per = int'(period); m_duty = int'(duty);
            m_dtr = int'(dt_rise); m_dtf = int'(dt_fall);
        end
        m_cnt = nxt;
        if (fault) m_flt = 1;
        else if (fault_clr) m_flt = 0;
        e.cnt = 6'(nxt);
        e.flt = (m_flt != 0);
        sb.push_back(e);

        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("pwm_hs", pwm_hs, e.hs);
        chk("pwm_ls", pwm_ls, e.ls);
        chk("cnt", cnt, e.cnt);
        chk("period_start", period_start, e.ps);
        chk("fault_lat", fault_lat, e.flt);
        chk("overlap", pwm_hs & pwm_ls, 0);

        if (pwm_ls && !prev_ls && last_high == 1) chk_ge("gap_hs_to_ls", low_run, cur_dtr);
        if (pwm_hs && !prev_hs && last_high == 2) chk_ge("gap_ls_to_hs", low_run, ls_dtf);
        if (pwm_hs) begin
            last_high = 1; low_run = 0;
        end else if (pwm_ls) begin
            last_high = 2; low_run = 0; ls_dtf = cur_dtf;
        end else begin
            low_run++;
        end
        if (!en) last_high = 0;
        prev_hs = pwm_hs;
        prev_ls = pwm_ls;
    endtask

    task automatic run_n(input int n, output int hs_n, output int ls_n, output int ps_at,
                         output int last_hs, output int first_ls);
        hs_n = 0; ls_n = 0; ps_at = 0; last_hs = 0; first_ls = 0;
        for (int i = 1; i <= n; i++) begin
            tick();
            if (pwm_hs) begin hs_n++; last_hs = i; end
            if (pwm_ls) begin ls_n++; if (first_ls == 0) first_ls = i; end
            if (period_start && ps_at == 0) ps_at = i;
        end
    endtask

    task automatic set_cfg(input int p, input int d, input int r, input int f);
        period = 6'(p); duty = 6'(d); dt_rise = 4'(r); dt_fall = 4'(f);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int hs_a, hs_b;
        rst_n = 1'b0; en = 1'b0; fault = 1'b0; fault_clr = 1'b0;
        set_cfg(63, 20, 6, 6);
        reset_model();
        #2;
        chk("rst_hs", pwm_hs, 0);
        chk("rst_ls", pwm_ls, 0);
        chk("rst_cnt", cnt, 0);
        chk("rst_ps", period_start, 0);
        chk("rst_flt", fault_lat, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Load shadows while disabled, then one full 64-count period.
        tick();
        en = 1'b1;
        run_n(64, nh, nl, pa, lh, fl);
        chk("p63_hs_count", nh, 20);
        chk("p63_ls_count", nl, 32);
        chk("p63_period_start_at", pa, 64);
        chk("p63_dead_rise", fl - lh - 1, 6);

        // Duty change mid-period only takes effect at the next boundary.
        run_n(10, nh, nl, pa, lh, fl);
        hs_a = nh;
        duty = 6'd40;
        run_n(54, nh, nl, pa, lh, fl);
        hs_b = nh;
        chk("duty_hold_hs_count", hs_a + hs_b, 20);
        run_n(64, nh, nl, pa, lh, fl);
        chk("duty40_hs_count", nh, 40);
        chk("duty40_ls_count", nl, 12);

        // Duty clamped against dead time.
        set_cfg(31, 63, 3, 2);
        run_n(64, nh, nl, pa, lh, fl);
        run_n(32, nh, nl, pa, lh, fl);
        chk("clamp_hs_count", nh, 27);
        chk("clamp_ls_count", nl, 0);
        chk("p31_period_start_at", pa, 32);

        // Dead times nearly consume the period.
        set_cfg(31, 20, 15, 15);
        run_n(32, nh, nl, pa, lh, fl);
        run_n(32, nh, nl, pa, lh, fl);
        chk("bigdt_hs_count", nh, 2);
        chk("bigdt_ls_count", nl, 0);

        // Fault handling.
        set_cfg(63, 20, 6, 6);
        run_n(32, nh, nl, pa, lh, fl);
        run_n(5, nh, nl, pa, lh, fl);
        chk("pre_fault_cnt", cnt, 5);
        fault = 1'b1;
        tick();
        chk("fault_hs_off", pwm_hs, 0);
        chk("fault_latched", fault_lat, 1);
        fault_clr = 1'b1;
        tick();
        chk("fault_wins_clr", fault_lat, 1);
        fault = 1'b0; fault_clr = 1'b0;
        tick();
        chk("fault_sticky", fault_lat, 1);
        chk("fault_sticky_hs", pwm_hs, 0);
        fault_clr = 1'b1;
        tick();
        chk("fault_cleared", fault_lat, 0);
        fault_clr = 1'b0;
        tick();
        chk("resume_hs", pwm_hs, 1);
        chk("resume_cnt", cnt, 10);

        // Enable drop mid-period.
        run_n(20, nh, nl, pa, lh, fl);
        chk("pre_en_cnt", cnt, 30);
        en = 1'b0;
        tick();
        chk("en_off_ls", pwm_ls, 0);
        chk("en_off_cnt", cnt, 0);
        en = 1'b1;
        run_n(64, nh, nl, pa, lh, fl);
        chk("reen_period_start_at", pa, 64);
        chk("reen_hs_count", nh, 20);

        // Asynchronous reset between clock edges.
        run_n(10, nh, nl, pa, lh, fl);
        chk("pre_rst_hs", pwm_hs, 1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_rst_hs", pwm_hs, 0);
        chk("async_rst_ls", pwm_ls, 0);
        chk("async_rst_cnt", cnt, 0);
        reset_model();
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Random sweep.
        for (int i = 0; i < 10000; i++) begin
            if ($urandom_range(19, 0) == 0)
                set_cfg($urandom_range(63, 4), $urandom_range(63, 0),
                        $urandom_range(15, 0), $urandom_range(15, 0));
            en        = ($urandom_range(199, 0) != 0);
            fault     = ($urandom_range(299, 0) == 0);
            fault_clr = ($urandom_range(39, 0) == 0);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
